shift_unit: RTL and testbench

Parametrised multi-cycle shift unit for the ALU datapath, successor to the single-bit left/right shifters. Accepts one operand, shift amount and mode through a valid/ready handshake. Shifts iteratively by up to STEP bits per clock, then holds the result with carry-out and zero flags until the consumer takes it. Sits between the ALU operand registers and the result mux. Small STEP values trade latency for area.

---
 rtl/shift_unit.sv | 143 ++++++++++++++
 tb/tb_shift_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Multi-cycle shift unit: accepts one operand over a valid/ready handshake, shifts
// up to STEP bits per clock in LSL/LSR/ASR/ROL mode, then holds the result until taken.
module shift_unit #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_zero
);

  localparam int AW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROL = 2'b11
  } op_t;

  state_t          state, state_d;
  op_t             op, op_d;
  logic [WIDTH-1:0] work, work_d;
  logic [AW-1:0]   remaining, remaining_d;
  logic            carry, carry_d;

  logic [31:0]      rem_wide;
  logic [31:0]      n_wide;
  logic [WIDTH-1:0] step_data;
  logic [WIDTH-1:0] spill;
  logic             step_carry;
  logic [AW-1:0]    rem_next;

  // One shift step of n = min(STEP, remaining) bits. n is formed at 32 bits so
  // STEP == WIDTH cannot wrap; remaining < WIDTH keeps the truncated n exact.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    step_data  = work;
    spill      = '0;
    step_carry = carry;
    rem_wide   = 32'(remaining);
    n_wide     = (rem_wide < 32'(STEP)) ? rem_wide : 32'(STEP);
    rem_next   = remaining - AW'(n_wide);
    case (op)
      OP_LSL: begin
        step_data  = work << n_wide;
        spill      = work >> (32'(WIDTH) - n_wide);
        step_carry = spill[0];
      end
      OP_LSR: begin
        step_data  = work >> n_wide;
        spill      = work >> (n_wide - 32'd1);
        step_carry = spill[0];
      end
      OP_ASR: begin
        // The working MSB never changes under ASR, so it is the latched sign.
        step_data  = $signed(work) >>> n_wide;
        spill      = work >> (n_wide - 32'd1);
        step_carry = spill[0];
      end
      OP_ROL: begin
        step_data  = (work << n_wide) | (work >> (32'(WIDTH) - n_wide));
        spill      = work >> (32'(WIDTH) - n_wide);
        step_carry = spill[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state;
    op_d        = op;
    work_d      = work;
    remaining_d = remaining;
    carry_d     = carry;
    if (flush) begin
      // Abort wins over both handshakes; the datapath is simply abandoned.
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work_d      = in_data;
            op_d        = op_t'(in_op);
            remaining_d = in_amt;
            carry_d     = 1'b0;
            state_d     = (in_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work_d      = step_data;
          carry_d     = step_carry;
          remaining_d = rem_next;
          if (rem_next == '0) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_LSL;
      work      <= '0;
      remaining <= '0;
      carry     <= 1'b0;
    end else begin
      state     <= state_d;
      op        <= op_d;
      work      <= work_d;
      remaining <= remaining_d;
      carry     <= carry_d;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;
  assign out_carry = carry;
  assign out_zero  = (work == '0);

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: a STEP=1 and a STEP=4 instance share stimulus,
// selected by sel; a monitor pops expected results on each output handshake.
module tb_shift_unit;

  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic             sel = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [AW-1:0]    in_amt = '0;
  logic [1:0]       in_op = '0;

  logic             in_ready1, out_valid1, out_carry1, out_zero1;
  logic [WIDTH-1:0] out_data1;
  logic             in_ready4, out_valid4, out_carry4, out_zero4;
  logic [WIDTH-1:0] out_data4;
  logic             in_valid1, in_valid4;

  logic             in_ready_s, out_valid_s, out_carry_s, out_zero_s;
  logic [WIDTH-1:0] out_data_s;

  assign in_valid1   = in_valid & ~sel;
  assign in_valid4   = in_valid & sel;
  assign in_ready_s  = sel ? in_ready4  : in_ready1;
  assign out_valid_s = sel ? out_valid4 : out_valid1;
  assign out_carry_s = sel ? out_carry4 : out_carry1;
  assign out_zero_s  = sel ? out_zero4  : out_zero1;
  assign out_data_s  = sel ? out_data4  : out_data1;

  shift_unit #(.WIDTH(WIDTH), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_carry(out_carry1), .out_zero(out_zero1)
  );

  shift_unit #(.WIDTH(WIDTH), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_carry(out_carry4), .out_zero(out_zero4)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
    int unsigned      acc;
    int unsigned      lat;
  } exp_t;

  typedef struct {
    logic             sel;
    logic [1:0]       op;
    logic [WIDTH-1:0] d;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] ed;
    logic             ec;
    int unsigned      lat;
  } vec_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Latency is counted in clock edges after the accepting edge (amt 0: result
  // visible in the very next cycle).
  vec_t vecs[12] = '{
    '{1'b0, 2'd0, 16'h8001, 4'd1,  16'h0002, 1'b1, 1},
    '{1'b0, 2'd1, 16'h00F0, 4'd4,  16'h000F, 1'b0, 4},
    '{1'b0, 2'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 15},
    '{1'b0, 2'd3, 16'h8001, 4'd1,  16'h0003, 1'b1, 1},
    '{1'b0, 2'd0, 16'h1234, 4'd0,  16'h1234, 1'b0, 0},
    '{1'b0, 2'd0, 16'h8000, 4'd1,  16'h0000, 1'b1, 1},
    '{1'b0, 2'd1, 16'h0003, 4'd2,  16'h0000, 1'b1, 2},
    '{1'b0, 2'd3, 16'h1234, 4'd4,  16'h2341, 1'b1, 4},
    '{1'b1, 2'd0, 16'h0001, 4'd15, 16'h8000, 1'b0, 4},
    '{1'b1, 2'd1, 16'hFFFF, 4'd6,  16'h03FF, 1'b1, 2},
    '{1'b1, 2'd3, 16'h8421, 4'd5,  16'h8430, 1'b0, 2},
    '{1'b1, 2'd2, 16'h8000, 4'd7,  16'hFF00, 1'b0, 2}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns after the accepting edge (again at posedge+1).
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic [AW-1:0] amt,
                       input bit push, input logic [WIDTH-1:0] ed, input logic ec,
                       input int unsigned elat, output int unsigned acc);
    bit ok;
    ok       = 1'b0;
    in_op    = op;
    in_data  = d;
    in_amt   = amt;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready_s && !flush;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    acc      = cyc;
    check("accept", 32'(ok), 32'd1);
    if (ok && push) sb.push_back('{ed, ec, (ed == '0), acc, elat});
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic count_valid(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid_s) hits++;
    end
    check(name, 32'(hits), 32'd0);
  endtask

  // Monitor: measures latency on first out_valid and compares on handshake.
  initial begin
    bit          seen;
    int unsigned lat;
    exp_t        e;
    seen = 1'b0;
    lat  = 0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid_s) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid_s), 32'd0);
        end else begin
          if (!seen) begin
            lat  = cyc - sb[0].acc;
            seen = 1'b1;
          end
          if (out_ready) begin
            e = sb.pop_front();
            check("out_data",  32'(out_data_s),  32'(e.data));
            check("out_carry", 32'(out_carry_s), 32'(e.carry));
            check("out_zero",  32'(out_zero_s),  32'(e.zero));
            check("latency",   lat,              e.lat);
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc, h;
    logic [WIDTH-1:0] d0;
    logic c0;
    bit got;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready_s),  32'd1);
    check("rst_out_valid", 32'(out_valid_s), 32'd0);
    check("rst_out_data",  32'(out_data_s),  32'h0);
    check("rst_out_zero",  32'(out_zero_s),  32'd1);
    check("rst_out_carry", 32'(out_carry_s), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors on both step sizes
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].sel != sel) begin
        drain();
        sel = vecs[i].sel;
      end
      issue(vecs[i].op, vecs[i].d, vecs[i].amt, 1'b1, vecs[i].ed, vecs[i].ec, vecs[i].lat, acc);
    end
    drain();
    sel = 1'b0;

    // Backpressure: result held for 5 cycles, then back-to-back accept
    out_ready = 1'b0;
    issue(2'd0, 16'h00FF, 4'd3, 1'b1, 16'h07F8, 1'b0, 3, acc);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = out_valid_s;
    end
    check("stall_valid_seen", 32'(got), 32'd1);
    d0 = out_data_s;
    c0 = out_carry_s;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_data[%0d]", i),  32'(out_data_s),  32'(d0));
      check($sformatf("stall_carry[%0d]", i), 32'(out_carry_s), 32'(c0));
      check($sformatf("stall_ready[%0d]", i), 32'(in_ready_s),  32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    h = cyc + 1;
    issue(2'd1, 16'h8000, 4'd1, 1'b1, 16'h4000, 1'b0, 1, acc);
    check("accept_after_handshake", acc - h, 32'd1);
    drain();

    // Flush 3 cycles into a shift
    issue(2'd0, 16'h0001, 4'd10, 1'b0, '0, 1'b0, 0, acc);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready_s), 32'd1);
    count_valid("flush_no_result", 20);

    // Flush together with in_valid while idle
    @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_data  = 16'h0001;
    in_amt   = 4'd2;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_not_accepted", 32'(in_ready_s), 32'd1);
    count_valid("flush_idle_no_result", 10);

    // Reset mid-shift
    @(posedge clk);
    #1;
    issue(2'd1, 16'hFFFF, 4'd10, 1'b0, '0, 1'b0, 0, acc);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid_s), 32'd0);
    check("midrst_in_ready",  32'(in_ready_s),  32'd1);
    check("midrst_out_data",  32'(out_data_s),  32'h0);
    check("midrst_out_zero",  32'(out_zero_s),  32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    count_valid("midrst_no_stale", 20);
    check("midrst_ready_after", 32'(in_ready_s), 32'd1);

    // Normal operation after reset
    @(posedge clk);
    #1;
    issue(2'd2, 16'h4000, 4'd3, 1'b1, 16'h0800, 1'b0, 3, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
